// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM encoding and default frame marker for the ITCM loader
package loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN_L, S_LEN_H, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: saturating inter-byte gap timer; run enables counting, kick restarts, expired at TIMEOUT_CYCLES-1
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic run,
  input  logic kick,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = run && cnt_q == LAST;
  always_comb cnt_d = (!run || kick) ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + W'(1));
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_itcm_loader.sv
// uart_itcm_loader: receives a sync/length/payload/xor-checksum frame over UART bytes and writes it into ITCM
// ports: clk_in/rst_in, rx_valid/rx_data byte strobe in, itcm_addr/itcm_data/itcm_wren write port, core_rst_n/load_done/load_err status
module uart_itcm_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [ADDR_WIDTH-1:0] itcm_addr,
  output logic [31:0]           itcm_data,
  output logic                  itcm_wren,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_err
);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] buf_q, buf_d;
  logic [7:0] chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic wren_q, wren_d;
  logic active, expired;
  logic [15:0] len_v;
  assign active = state_q inside {S_LEN_L, S_LEN_H, S_DATA, S_CHK};
  assign len_v = {rx_data, len_q[7:0]};
  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_in(clk_in), .rst_in(rst_in), .run(active), .kick(rx_valid), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    bcnt_d = bcnt_q;
    buf_d = buf_q;
    chk_d = chk_q;
    data_d = data_q;
    wren_d = 1'b0;
    // the address advances the cycle after each write so it is stable during the pulse
    addr_d = wren_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
    case (state_q)
      S_IDLE, S_ERR:
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_LEN_L;
          addr_d = '0;
          chk_d = '0;
          bcnt_d = '0;
        end
      S_LEN_L:
        if (rx_valid) begin
          len_d = {8'h00, rx_data};
          state_d = S_LEN_H;
        end else if (expired) state_d = S_ERR;
      S_LEN_H:
        if (rx_valid) begin
          len_d = len_v;
          state_d = len_v == 16'd0 ? S_CHK :
                    {16'd0, len_v} > (32'd1 << ADDR_WIDTH) ? S_ERR : S_DATA;
        end else if (expired) state_d = S_ERR;
      S_DATA:
        if (rx_valid) begin
          chk_d = chk_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          buf_d = {rx_data, buf_q[23:8]};
          if (bcnt_q == 2'd3) begin
            data_d = {rx_data, buf_q};
            wren_d = 1'b1;
            len_d = len_q - 16'd1;
            state_d = len_q == 16'd1 ? S_CHK : S_DATA;
          end
        end else if (expired) state_d = S_ERR;
      S_CHK:
        if (rx_valid) state_d = rx_data == chk_q ? S_DONE : S_ERR;
        else if (expired) state_d = S_ERR;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= S_IDLE;
      len_q <= '0;
      bcnt_q <= '0;
      buf_q <= '0;
      chk_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      bcnt_q <= bcnt_d;
      buf_q <= buf_d;
      chk_q <= chk_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wren_q <= wren_d;
    end
  assign itcm_addr = addr_q;
  assign itcm_data = data_q;
  assign itcm_wren = wren_q;
  assign core_rst_n = state_q == S_DONE;
  assign load_done = state_q == S_DONE;
  assign load_err = state_q == S_ERR;
endmodule

// File: tb/tb_uart_itcm_loader.sv
// tb_uart_itcm_loader: directed frame tests for uart_itcm_loader with a write monitor
module tb_uart_itcm_loader;
  localparam int AW = 4;
  localparam int TO = 50;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [AW-1:0] itcm_addr;
  logic [31:0] itcm_data;
  logic itcm_wren, core_rst_n, load_done, load_err;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int base;
  logic [AW-1:0] last_addr = '0;
  logic [31:0] last_data = '0;
  uart_itcm_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_valid(rx_valid), .rx_data(rx_data),
    .itcm_addr(itcm_addr), .itcm_data(itcm_data), .itcm_wren(itcm_wren),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );
  always #5 clk_in = ~clk_in;
  always @(negedge clk_in)
    if (itcm_wren) begin
      wr_cnt = wr_cnt + 1;
      last_addr = itcm_addr;
      last_data = itcm_data;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk_in);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask
  task automatic frame_good();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h08);
    idle(3);
  endtask
  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    idle(2);
  endtask
  initial begin
    idle(3);
    chk("rst_wren", {31'd0, itcm_wren}, 32'd0);
    chk("rst_addr", {28'd0, itcm_addr}, 32'd0);
    chk("rst_data", itcm_data, 32'd0);
    chk("rst_core", {31'd0, core_rst_n}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    rst_in = 1'b0;
    idle(2);
    base = wr_cnt;
    send(8'h11); send(8'h01); send(8'h00); send(8'h08);
    idle(2);
    chk("idle_discard_err", {31'd0, load_err}, 32'd0);
    frame_good();
    chk("good_writes", wr_cnt - base, 32'd1);
    chk("good_addr", {28'd0, last_addr}, 32'd0);
    chk("good_data", last_data, 32'h12345678);
    chk("good_done", {31'd0, load_done}, 32'd1);
    chk("good_core", {31'd0, core_rst_n}, 32'd1);
    chk("good_err", {31'd0, load_err}, 32'd0);
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    idle(2);
    chk("done_ignore_writes", wr_cnt - base, 32'd0);
    chk("done_stays", {31'd0, load_done}, 32'd1);
    do_reset();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h09);
    idle(2);
    chk("badchk_err", {31'd0, load_err}, 32'd1);
    chk("badchk_core", {31'd0, core_rst_n}, 32'd0);
    chk("badchk_done", {31'd0, load_done}, 32'd0);
    base = wr_cnt;
    frame_good();
    chk("recover_done", {31'd0, load_done}, 32'd1);
    chk("recover_err", {31'd0, load_err}, 32'd0);
    chk("recover_addr", {28'd0, last_addr}, 32'd0);
    chk("recover_writes", wr_cnt - base, 32'd1);
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    chk("len0_done", {31'd0, load_done}, 32'd1);
    chk("len0_writes", wr_cnt - base, 32'd0);
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    idle(TO - 10);
    chk("gap_not_yet", {31'd0, load_err}, 32'd0);
    idle(15);
    chk("gap_err", {31'd0, load_err}, 32'd1);
    chk("gap_writes", wr_cnt - base, 32'd1);
    chk("gap_addr", {28'd0, last_addr}, 32'd0);
    chk("gap_data", last_data, 32'h44332211);
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_wren", {31'd0, itcm_wren}, 32'd0);
    chk("midrst_addr", {28'd0, itcm_addr}, 32'd0);
    chk("midrst_data", itcm_data, 32'd0);
    chk("midrst_status", {29'd0, core_rst_n, load_done, load_err}, 32'd0);
    rst_in = 1'b0;
    idle(3);
    chk("midrst_nowrite", wr_cnt - base, 32'd0);
    frame_good();
    chk("midrst_reload_addr", {28'd0, last_addr}, 32'd0);
    chk("midrst_reload_data", last_data, 32'h12345678);
    chk("midrst_reload_done", {31'd0, load_done}, 32'd1);
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h11); send(8'h00);
    idle(2);
    chk("len17_err", {31'd0, load_err}, 32'd1);
    chk("len17_writes", wr_cnt - base, 32'd0);
    send(8'hA5); send(8'h10); send(8'h00);
    for (int i = 0; i < 64; i++) send(8'(i));
    send(8'h00);
    idle(3);
    chk("len16_writes", wr_cnt - base, 32'd16);
    chk("len16_last_addr", {28'd0, last_addr}, 32'd15);
    chk("len16_last_data", last_data, 32'h3F3E3D3C);
    chk("len16_done", {31'd0, load_done}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_itcm_loader.md
UART_ITCM_LOADER -- requirements
Module: uart_itcm_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, ITCM word-address width.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500_000, maximum allowed clk_in cycles between bytes inside a frame (10 ms at 50 MHz).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, named as follows.
REQ-005 SHALL have port clk_in  input  1  system clock.
REQ-006 SHALL have port rst_in  input  1  asynchronous active-high reset.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe marking a received UART byte.
REQ-008 SHALL have port rx_data  input  8  received byte, qualified by rx_valid.
REQ-009 SHALL have port itcm_addr  output  ADDR_WIDTH  ITCM word address.
REQ-010 SHALL have port itcm_data  output  32  ITCM write data.
REQ-011 SHALL have port itcm_wren  output  1  ITCM write enable, one-cycle pulse.
REQ-012 SHALL have port core_rst_n  output  1  core reset, active low, released only after a good load.
REQ-013 SHALL have port load_done  output  1  high once a frame has verified.
REQ-014 SHALL have port load_err  output  1  high after a frame error until the next SYNC_BYTE.

Function
REQ-015 SHALL accept the frame format SYNC_BYTE, LEN_LO, LEN_HI, then LEN*4 payload bytes (little-endian words), then CHK, where LEN is a 16-bit word count.
REQ-016 SHALL define CHK as the XOR of all payload bytes (0x00 when LEN=0).
REQ-017 SHALL implement the states IDLE, LEN_L, LEN_H, DATA, CHK, DONE and ERR.
REQ-018 SHALL stay in IDLE, discarding bytes, until rx_data==SYNC_BYTE, then enter LEN_L.
REQ-019 SHALL move LEN_H to DATA when LEN>0, to CHK when LEN==0, and to ERR when LEN>2**ADDR_WIDTH.
REQ-020 SHALL assemble 4 payload bytes, the first byte into bits [7:0], then pulse itcm_wren for exactly one cycle, in the cycle after the 4th byte's rx_valid.
REQ-021 SHALL hold itcm_data and itcm_addr stable during the itcm_wren cycle, with the first word at address 0 and the address then incrementing by 1 per word.
REQ-022 SHALL enter CHK after the LEN-th word is written.
REQ-023 SHALL enter DONE on a CHK match and ERR on a mismatch.
REQ-024 SHALL, in DONE, set core_rst_n=1 and load_done=1, ignore all further bytes, and leave DONE only on reset.
REQ-025 SHALL, in ERR, set load_err=1 and keep core_rst_n=0.
REQ-026 SHALL, in ERR, clear load_err on a SYNC_BYTE and enter LEN_L, resetting the address, the checksum and the byte counter.
REQ-027 SHALL restart the gap counter on every rx_valid while in LEN_L, LEN_H, DATA or CHK.
REQ-028 SHALL enter ERR when the gap counter reaches TIMEOUT_CYCLES-1 in those states; the counter SHALL saturate and never wrap.
REQ-029 SHALL give rx_valid priority when a byte and the timeout coincide in the same cycle.
REQ-030 SHALL NOT write partial words; words written before an error are not rolled back.
REQ-031 SHALL treat SYNC_BYTE as ordinary data in every state except IDLE and ERR.

Reset
REQ-032 SHALL, on rst_in, asynchronously force state=IDLE, itcm_wren=0, itcm_addr=0, itcm_data=0, core_rst_n=0, load_done=0, load_err=0, and clear all counters and the checksum.
REQ-033 SHALL abandon any frame in progress on rst_in, with no write pulse during or after reset.

Structure
REQ-034 SHALL place the state encodings and the default SYNC_BYTE in a shared package, loader_pkg.
REQ-035 SHALL be one flat module, except that the gap timer MAY be a sub-module named loader_timeout.

Verification
REQ-036 SHALL cover: A5 01 00 78 56 34 12 08 -> one itcm_wren, addr 0, data 0x12345678, then load_done=1 and core_rst_n=1.
REQ-037 SHALL cover: the same frame with CHK=09 -> load_err=1, core_rst_n=0; a following good frame -> load_done=1.
REQ-038 SHALL cover: A5 00 00 00 -> DONE with no itcm_wren pulse.
REQ-039 SHALL cover: A5 02 00, then 5 payload bytes and silence for TIMEOUT_CYCLES -> ERR, and exactly one write to address 0.
REQ-040 SHALL cover: rst_in asserted mid-payload -> all outputs at reset values, and a new full frame loads from address 0.
REQ-041 SHALL cover: with ADDR_WIDTH=4, LEN=17 -> ERR straight after LEN_H with no writes; LEN=16 -> last write at address 15.
